// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmit byte port between two valid/ready byte requesters
// Ports: clk, reset_n_i (sync, active-low); req0_*/req1_* requester byte streams;
// tx_data_o/tx_valid_o/tx_ready_i toward the UART; owner_o current grant; timeout_o forced-release pulse.
module uart_tx_arbiter #(
    parameter bit          PACKET_MODE    = 1'b1,
    parameter logic [7:0]  DELIM          = 8'h0A,
    parameter int unsigned TIMEOUT_CYCLES = 1200000,
    parameter int unsigned TW             = 21
) (
    input  logic       clk,
    input  logic       reset_n_i,
    input  logic [7:0] req0_data_i,
    input  logic       req0_valid_i,
    output logic       req0_ready_o,
    input  logic [7:0] req1_data_i,
    input  logic       req1_valid_i,
    output logic       req1_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic [1:0] owner_o,
    output logic       timeout_o
);
    // encoding doubles as the owner_o decode
    typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;
    state_t        r_state;
    state_t        w_next;
    logic          r_last;
    logic [TW-1:0] r_cnt;
    logic [7:0]    r_tx_data;
    logic          r_tx_valid;
    logic          r_timeout;
    logic          w_owning;
    logic          w_slot_free;
    logic          w_own_valid;
    logic [7:0]    w_own_data;
    logic          w_accept;
    logic          w_release;
    logic          w_tick;
    logic          w_expire;
    assign w_owning    = (r_state == OWN0) || (r_state == OWN1);
    assign w_slot_free = !r_tx_valid || tx_ready_i;
    assign w_own_valid = (r_state == OWN1) ? req1_valid_i : req0_valid_i;
    assign w_own_data  = (r_state == OWN1) ? req1_data_i : req0_data_i;
    assign w_accept    = w_owning && w_own_valid && w_slot_free;
    assign w_release   = w_accept && (!PACKET_MODE || w_own_data == DELIM);
    // idle-owner cycles only; backpressure stalls with valid high never count
    assign w_tick      = w_owning && !w_own_valid;
    // an accepted delimiter always wins over the timeout
    assign w_expire    = w_tick && (r_cnt == TW'(TIMEOUT_CYCLES - 1)) && !w_release;
    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_cnt      <= '0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_timeout <= w_expire;
            if (w_release || w_expire)
                r_last <= (r_state == OWN1);
            r_cnt <= (!w_owning || w_accept || w_expire) ? '0 : w_tick ? r_cnt + TW'(1) : r_cnt;
            if (w_accept) begin
                r_tx_data  <= w_own_data;
                r_tx_valid <= 1'b1;
            end else if (tx_ready_i) begin
                r_tx_valid <= 1'b0;
            end
        end
    end
    // on a tie the requester not served last wins
    always_comb begin
        w_next = IDLE;
        if (r_state == IDLE)
            w_next = (req0_valid_i && req1_valid_i) ? (r_last ? OWN0 : OWN1) :
                     req0_valid_i ? OWN0 : req1_valid_i ? OWN1 : IDLE;
        else if (w_owning)
            w_next = (w_release || w_expire) ? IDLE : r_state;
    end
    always_comb begin
        req0_ready_o = (r_state == OWN0) && w_slot_free;
        req1_ready_o = (r_state == OWN1) && w_slot_free;
        owner_o      = r_state;
        tx_data_o    = r_tx_data;
        tx_valid_o   = r_tx_valid;
        timeout_o    = r_timeout;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: checks a packet-mode and a per-byte-mode arbiter against a cycle model and literal traces
module tb_uart_tx_arbiter;
    localparam int T = 8;
    localparam logic [7:0] LF = 8'h0A;
    typedef struct {
        int         own;
        bit         last;
        int         cnt;
        bit         tv;
        logic [7:0] td;
        bit         to;
    } mdl_t;
    logic       clk;
    logic       rst_n [2];
    logic       tr    [2];
    logic       v     [2][2];
    logic [7:0] dat   [2][2];
    logic       rdy   [2][2];
    logic [7:0] td_o  [2];
    logic       tv_o  [2];
    logic [1:0] own_o [2];
    logic       to_o  [2];
    logic [7:0] q     [2][2][$];
    logic [7:0] got   [2][$];
    logic [7:0] exp_q [$];
    bit         take  [2][2];
    bit         armed = 0;
    mdl_t       m     [2];
    int         total = 0;
    int         bad   = 0;

    uart_tx_arbiter #(.PACKET_MODE(1'b1), .DELIM(LF), .TIMEOUT_CYCLES(T), .TW(4)) u_pkt (
        .clk(clk), .reset_n_i(rst_n[0]),
        .req0_data_i(dat[0][0]), .req0_valid_i(v[0][0]), .req0_ready_o(rdy[0][0]),
        .req1_data_i(dat[0][1]), .req1_valid_i(v[0][1]), .req1_ready_o(rdy[0][1]),
        .tx_data_o(td_o[0]), .tx_valid_o(tv_o[0]), .tx_ready_i(tr[0]),
        .owner_o(own_o[0]), .timeout_o(to_o[0])
    );
    uart_tx_arbiter #(.PACKET_MODE(1'b0), .DELIM(LF), .TIMEOUT_CYCLES(T), .TW(4)) u_byte (
        .clk(clk), .reset_n_i(rst_n[1]),
        .req0_data_i(dat[1][0]), .req0_valid_i(v[1][0]), .req0_ready_o(rdy[1][0]),
        .req1_data_i(dat[1][1]), .req1_valid_i(v[1][1]), .req1_ready_o(rdy[1][1]),
        .tx_data_o(td_o[1]), .tx_valid_o(tv_o[1]), .tx_ready_i(tr[1]),
        .owner_o(own_o[1]), .timeout_o(to_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic chk_seq(input int d, input string n);
        chk($sformatf("%s_len", n), got[d].size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got[d].size(); i++)
            chk($sformatf("%s_byte%0d", n, i), got[d][i], exp_q[i]);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // what the arbiter must look like after the coming clock edge, given its rules
    function automatic mdl_t step(input mdl_t c, input bit pkt, input bit rn, input bit v0, input bit v1,
                                  input logic [7:0] d0, input logic [7:0] d1, input bit trdy);
        mdl_t       n = c;
        bit         vv;
        logic [7:0] dd;
        n.to = 0;
        if (!rn) begin
            n.own = 0; n.last = 1; n.cnt = 0; n.tv = 0; n.td = 8'h00;
            return n;
        end
        if (c.own == 0) begin
            if (trdy) n.tv = 0;
            if (v0 && v1) n.own = c.last ? 1 : 2;
            else if (v0) n.own = 1;
            else if (v1) n.own = 2;
            return n;
        end
        vv = (c.own == 1) ? v0 : v1;
        dd = (c.own == 1) ? d0 : d1;
        if (vv && (!c.tv || trdy)) begin
            n.td = dd; n.tv = 1; n.cnt = 0;
            if (!pkt || dd == LF) begin
                n.own = 0; n.last = (c.own == 2);
            end
        end else begin
            if (trdy) n.tv = 0;
            if (!vv) begin
                if (c.cnt == T - 1) begin
                    n.own = 0; n.last = (c.own == 2); n.to = 1; n.cnt = 0;
                end else begin
                    n.cnt++;
                end
            end
        end
        return n;
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (armed) begin
                chk($sformatf("d%0d_owner", d), own_o[d], (m[d].own == 0) ? 2'b00 : (m[d].own == 1) ? 2'b01 : 2'b10);
                chk($sformatf("d%0d_tx_valid", d), tv_o[d], m[d].tv);
                chk($sformatf("d%0d_tx_data", d), td_o[d], m[d].td);
                chk($sformatf("d%0d_timeout", d), to_o[d], m[d].to);
                chk($sformatf("d%0d_ready0", d), rdy[d][0], m[d].own == 1 && (!m[d].tv || tr[d]));
                chk($sformatf("d%0d_ready1", d), rdy[d][1], m[d].own == 2 && (!m[d].tv || tr[d]));
            end
            if (rst_n[d] && tv_o[d] && tr[d]) got[d].push_back(td_o[d]);
            m[d] = step(m[d], d == 0, rst_n[d], v[d][0], v[d][1], dat[d][0], dat[d][1], tr[d]);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                for (int r = 0; r < 2; r++)
                    take[d][r] = rst_n[d] && v[d][r] && rdy[d][r];
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++)
                for (int r = 0; r < 2; r++) begin
                    if (take[d][r]) void'(q[d][r].pop_front());
                    v[d][r]   = q[d][r].size() > 0;
                    dat[d][r] = v[d][r] ? q[d][r][0] : 8'h00;
                end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            m[d] = '{own: 0, last: 1, cnt: 0, tv: 0, td: 8'h00, to: 0};
            rst_n[d] = 1'b0;
            tr[d] = 1'b1;
            for (int r = 0; r < 2; r++) begin
                v[d][r] = 1'b0;
                dat[d][r] = 8'h00;
            end
        end
        q[0][0] = '{8'h41, 8'h42, LF};
        q[0][1] = '{8'h78, 8'h79, LF};
        @(posedge clk);
        #1 armed = 1;
        tick(3);
        chk("rst_owner", own_o[0], 2'b00);
        chk("rst_tx_valid", tv_o[0], 1'b0);
        chk("rst_ready0", rdy[0][0], 1'b0);
        chk("rst_ready1", rdy[0][1], 1'b0);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        tick(1);
        chk("first_tie_req0", own_o[0], 2'b01);
        tick(3);
        chk("pkt_bubble", own_o[0], 2'b00);
        tick(1);
        chk("pkt_owner_req1", own_o[0], 2'b10);
        tick(6);
        exp_q = '{8'h41, 8'h42, LF, 8'h78, 8'h79, LF};
        chk_seq(0, "pkt_lock");
        got[0].delete();
        q[0][0] = '{8'h31, 8'h32, 8'h33, LF};
        tick(3);
        tr[0] = 1'b0;
        tick(10);
        chk("bp_data_stable", td_o[0], 8'h31);
        chk("bp_valid_held", tv_o[0], 1'b1);
        chk("bp_ready0_low", rdy[0][0], 1'b0);
        chk("bp_no_timeout", to_o[0], 1'b0);
        tr[0] = 1'b1;
        tick(8);
        exp_q = '{8'h31, 8'h32, 8'h33, LF};
        chk_seq(0, "backpressure");
        got[0].delete();
        q[0][0] = '{8'h41};
        tick(2);
        q[0][1] = '{8'h61, 8'h62, LF};
        tick(1);
        chk("to_owner_req0", own_o[0], 2'b01);
        tick(7);
        chk("to_not_yet", to_o[0], 1'b0);
        chk("to_still_req0", own_o[0], 2'b01);
        tick(1);
        chk("to_pulse", to_o[0], 1'b1);
        chk("to_released", own_o[0], 2'b00);
        tick(1);
        chk("to_pulse_end", to_o[0], 1'b0);
        chk("to_owner_req1", own_o[0], 2'b10);
        tick(6);
        exp_q = '{8'h41, 8'h61, 8'h62, LF};
        chk_seq(0, "timeout");
        got[0].delete();
        q[0][1] = '{8'h71, 8'h72, LF};
        tick(3);
        chk("mid_owner_req1", own_o[0], 2'b10);
        chk("mid_tx_valid", tv_o[0], 1'b1);
        rst_n[0] = 1'b0;
        q[0][0] = '{8'h51, LF};
        tick(1);
        chk("mid_rst_drop", tv_o[0], 1'b0);
        chk("mid_rst_owner", own_o[0], 2'b00);
        rst_n[0] = 1'b1;
        got[0].delete();
        tick(1);
        chk("mid_tie_req0", own_o[0], 2'b01);
        tick(8);
        exp_q = '{8'h51, LF, 8'h72, LF};
        chk_seq(0, "mid_reset");
        q[1][0] = '{8'h01, 8'h02, 8'h03};
        q[1][1] = '{8'h11, 8'h12, 8'h13};
        tick(2);
        chk("byte_owner_req0", own_o[1], 2'b01);
        tick(1);
        chk("byte_bubble", own_o[1], 2'b00);
        tick(1);
        chk("byte_owner_req1", own_o[1], 2'b10);
        tick(14);
        exp_q = '{8'h01, 8'h11, 8'h02, 8'h12, 8'h03, 8'h13};
        chk_seq(1, "per_byte");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
